// File: rtl/sum4_residual_checker.sv
// Serial checker: takes a claimed total, subtracts NUM_OPS operands, reports the signed residual and a match flag.
// Latency: result is valid the cycle after the final operand is accepted (1+NUM_OPS+1 cycles per frame minimum).
// Backpressure: result holds while res_ready is low; sum_ready/op_ready stay low until the result is taken.
module sum4_residual_checker #(
    parameter int OP_W    = 8,
    parameter int NUM_OPS = 4,
    parameter int SUM_W   = OP_W + $clog2(NUM_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sum_valid,
    output logic             sum_ready,
    input  logic [SUM_W-1:0] sum_data,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OP_W-1:0]  op_data,
    input  logic             op_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SUM_W:0]   residual,
    output logic             match,
    output logic             frame_err
);

    localparam int              CNT_W   = $clog2(NUM_OPS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_OPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             live;
    logic [SUM_W:0]   acc;
    logic [SUM_W:0]   acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             err_nxt;
    logic             match_q;
    logic             sum_fire;
    logic             op_fire;
    logic             res_fire;
    logic             cnt_at_max;
    logic             final_op;

    assign sum_fire = sum_valid & sum_ready;
    assign op_fire  = op_valid & op_ready;
    assign res_fire = res_valid & res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (sum_fire) begin
                    state_nxt = S_SUB;
                end
            end
            S_SUB: begin
                if (op_fire && final_op) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (res_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Ready/valid come from registered state only; sum_ready additionally waits one edge past reset release.
    always_comb begin
        sum_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE:  sum_ready = live;
            S_SUB:   op_ready  = 1'b1;
            S_RESP:  res_valid = 1'b1;
            default: ;
        endcase
    end

    assign acc_nxt    = acc - {{(SUM_W + 1 - OP_W){1'b0}}, op_data};
    assign cnt_at_max = (cnt == CNT_MAX);
    assign final_op   = op_last | cnt_at_max;
    // Early op_last is a short frame; at the last slot a missing op_last is a long/unterminated frame.
    assign err_nxt    = cnt_at_max ? (err | ~op_last) : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            match_q <= 1'b0;
        end else begin
            live <= 1'b1;
            if (sum_fire) begin
                acc     <= {1'b0, sum_data};
                cnt     <= '0;
                err     <= 1'b0;
                match_q <= 1'b0;
            end else if (op_fire) begin
                acc <= acc_nxt;
                if (final_op) begin
                    err     <= err_nxt;
                    match_q <= (acc_nxt == '0) & ~err_nxt;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign residual  = acc;
    assign match     = match_q;
    assign frame_err = err;

endmodule
